// File: rtl/fb_write_arbiter_if.sv
// Framebuffer port-A write bus shared by two requesters and the arbiter.
// The arbiter takes the slave side. Requesters or the bench take the master side.
interface fb_write_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [7:0]        data0;
    logic [7:0]        data1;
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] ram_address;
    logic [7:0]        ram_data_out;
    logic              ram_write_enable;
    logic              ram_clk_enable;
    logic              busy;
    logic [7:0]        wait_count;

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, data0, data1,
        input  gnt0, gnt1, ram_address, ram_data_out, ram_write_enable,
               ram_clk_enable, busy, wait_count
    );

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, data0, data1,
        output gnt0, gnt1, ram_address, ram_data_out, ram_write_enable,
               ram_clk_enable, busy, wait_count
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for framebuffer write port A. It locks the port for a burst,
// bounds the burst length, and inserts one dead cycle between owners.
module fb_write_arbiter #(
    parameter int PIXEL_WIDTH     = 64,
    parameter int PIXEL_HEIGHT    = 32,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int MAX_BURST       = 16
) (
    input  logic               clk_in,
    input  logic               reset,
    fb_write_arbiter_if.slave  bus
);
    localparam int ADDR_W = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL);
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, HANDOFF} state_t;

    state_t            state;
    state_t            next_state;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              last_owner;
    logic [CNT_W-1:0]  burst_cnt;
    logic [ADDR_W-1:0] address_q;
    logic [7:0]        data_q;
    logic              write_q;
    logic [7:0]        wait_q;

    logic              accept0;
    logic              accept1;
    logic              accept_any;
    logic              burst_full;
    logic              waiting;

    // State register. A grant issued from IDLE is held back one cycle, which gives
    // the two-edge request-to-grant latency. A grant that follows HANDOFF starts
    // right away.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments only. Then every
        // flop samples pre-edge values, whatever order the statements are in.
        if (reset) begin
            state  <= IDLE;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
        end else begin
            state  <= next_state;
            gnt0_q <= (next_state == GRANT0) && (state != IDLE);
            gnt1_q <= (next_state == GRANT1) && (state != IDLE);
        end
    end

    // Burst limit counts the write being accepted this cycle. Then the owner
    // releases the port on the edge of its MAX_BURST-th write.
    always_comb begin
        // NOTE: each combinational output gets a default first. Then no path
        // leaves it unassigned, and no latch is inferred.
        next_state = state;
        burst_full = (burst_cnt == BURST_MAX) ||
                     (accept_any && (burst_cnt == BURST_MAX - CNT_W'(1)));
        unique case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) next_state = last_owner ? GRANT0 : GRANT1;
                else if (bus.req0)        next_state = GRANT0;
                else if (bus.req1)        next_state = GRANT1;
            end
            GRANT0: begin
                if (!bus.req0 || (burst_full && bus.req1))
                    next_state = bus.req1 ? HANDOFF : IDLE;
            end
            GRANT1: begin
                if (!bus.req1 || (burst_full && bus.req0))
                    next_state = bus.req0 ? HANDOFF : IDLE;
            end
            HANDOFF: begin
                if (last_owner) next_state = bus.req0 ? GRANT0 : IDLE;
                else            next_state = bus.req1 ? GRANT1 : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: write acceptance and requester-waiting status.
    always_comb begin
        accept0    = gnt0_q && bus.req0 && bus.wr0;
        accept1    = gnt1_q && bus.req1 && bus.wr1;
        accept_any = accept0 || accept1;
        waiting    = (bus.req0 && !gnt0_q) || (bus.req1 && !gnt1_q);
    end

    // Datapath: burst counter, round-robin memory, registered RAM-side bus and wait counter.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            address_q  <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
            wait_q     <= '0;
        end else begin
            if (state == GRANT0 && next_state != GRANT0) last_owner <= 1'b0;
            if (state == GRANT1 && next_state != GRANT1) last_owner <= 1'b1;

            if (next_state != state && (next_state == GRANT0 || next_state == GRANT1))
                burst_cnt <= '0;
            else if (accept_any && burst_cnt != BURST_MAX)
                burst_cnt <= burst_cnt + CNT_W'(1);

            write_q <= accept_any;
            if (accept0) begin
                address_q <= bus.addr0;
                data_q    <= bus.data0;
            end else if (accept1) begin
                address_q <= bus.addr1;
                data_q    <= bus.data1;
            end

            if (waiting && wait_q != 8'hFF) wait_q <= wait_q + 8'd1;
        end
    end

    assign bus.gnt0             = gnt0_q;
    assign bus.gnt1             = gnt1_q;
    assign bus.ram_address      = address_q;
    assign bus.ram_data_out     = data_q;
    assign bus.ram_write_enable = write_q;
    assign bus.ram_clk_enable   = write_q;
    assign bus.busy             = (state != IDLE);
    assign bus.wait_count       = wait_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter. It covers reset, bursts, forced
// handoff, stray writes, tie-breaking, reset mid-burst and wait-count saturation.
module tb_fb_write_arbiter;
    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fb_write_arbiter_if #(.ADDR_W(12)) bus ();

    fb_write_arbiter dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.data0 = '0; bus.data1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        idle_inputs();

        // T1: reset held with both requests high, then the grant arrives two edges after release
        reset = 1; bus.req0 = 1; bus.req1 = 1;
        tick(); tick(); tick();
        check("t1_gnt0_rst", 32'(bus.gnt0), 0);
        check("t1_gnt1_rst", 32'(bus.gnt1), 0);
        check("t1_we_rst", 32'(bus.ram_write_enable), 0);
        check("t1_wait_rst", 32'(bus.wait_count), 0);
        check("t1_busy_rst", 32'(bus.busy), 0);
        reset = 0;
        tick();
        check("t1_gnt0_edge1", 32'(bus.gnt0), 0);
        tick();
        check("t1_gnt0_edge2", 32'(bus.gnt0), 1);
        check("t1_gnt1_edge2", 32'(bus.gnt1), 0);
        check("t1_wait_edge2", 32'(bus.wait_count), 2);

        // T2: a single five-write burst on req0
        do_reset();
        bus.req0 = 1;
        tick(); tick();
        check("t2_gnt0", 32'(bus.gnt0), 1);
        for (int i = 0; i < 5; i++) begin
            bus.wr0 = 1; bus.addr0 = 12'h010 + 12'(i); bus.data0 = 8'hA0 + 8'(i);
            tick();
            check("t2_we", 32'(bus.ram_write_enable), 1);
            check("t2_ce", 32'(bus.ram_clk_enable), 1);
            check("t2_addr", 32'(bus.ram_address), 32'h010 + 32'(i));
            check("t2_data", 32'(bus.ram_data_out), 32'hA0 + 32'(i));
            check("t2_gnt1", 32'(bus.gnt1), 0);
        end
        bus.wr0 = 0;
        tick();
        check("t2_we_low", 32'(bus.ram_write_enable), 0);
        check("t2_addr_hold", 32'(bus.ram_address), 32'h014);
        check("t2_data_hold", 32'(bus.ram_data_out), 32'hA4);
        bus.req0 = 0;
        tick();
        check("t2_gnt0_drop", 32'(bus.gnt0), 0);
        check("t2_busy_idle", 32'(bus.busy), 0);
        check("t2_wait", 32'(bus.wait_count), 2);

        // T3: forced handoff after sixteen writes while req1 is waiting
        do_reset();
        bus.req0 = 1; bus.req1 = 1;
        tick(); tick();
        check("t3_gnt0", 32'(bus.gnt0), 1);
        for (int i = 0; i < 16; i++) begin
            bus.wr0 = 1; bus.addr0 = 12'h100 + 12'(i); bus.data0 = 8'(i);
            tick();
            check("t3_we", 32'(bus.ram_write_enable), 1);
            check("t3_addr", 32'(bus.ram_address), 32'h100 + 32'(i));
            check("t3_gnt0_burst", 32'(bus.gnt0), (i < 15) ? 32'd1 : 32'd0);
        end
        check("t3_handoff_gnt1", 32'(bus.gnt1), 0);
        check("t3_handoff_busy", 32'(bus.busy), 1);
        bus.addr0 = 12'h1FF;
        tick();
        check("t3_handoff_no_we", 32'(bus.ram_write_enable), 0);
        check("t3_gnt1_after", 32'(bus.gnt1), 1);
        check("t3_gnt0_after", 32'(bus.gnt0), 0);
        check("t3_addr_hold", 32'(bus.ram_address), 32'h10F);
        bus.wr0 = 0;

        // T4: a stray write on port 1 while req0 owns the port
        do_reset();
        bus.req0 = 1;
        tick(); tick();
        bus.wr0 = 1; bus.addr0 = 12'h020; bus.data0 = 8'h55;
        bus.wr1 = 1; bus.addr1 = 12'h0FF; bus.data1 = 8'hEE;
        tick();
        check("t4_we", 32'(bus.ram_write_enable), 1);
        check("t4_addr", 32'(bus.ram_address), 32'h020);
        check("t4_data", 32'(bus.ram_data_out), 32'h55);
        bus.wr0 = 0;
        tick();
        check("t4_stray_we", 32'(bus.ram_write_enable), 0);
        check("t4_stray_addr", 32'(bus.ram_address), 32'h020);
        check("t4_gnt1", 32'(bus.gnt1), 0);
        check("t4_gnt0", 32'(bus.gnt0), 1);

        // T5: a tie, then round-robin after req0 drops, then the next tie goes to req0
        do_reset();
        bus.req0 = 1; bus.req1 = 1;
        tick(); tick();
        check("t5_tie_gnt0", 32'(bus.gnt0), 1);
        check("t5_tie_gnt1", 32'(bus.gnt1), 0);
        bus.req0 = 0;
        tick();
        check("t5_handoff_gnt0", 32'(bus.gnt0), 0);
        check("t5_handoff_gnt1", 32'(bus.gnt1), 0);
        tick();
        check("t5_gnt1", 32'(bus.gnt1), 1);
        bus.req1 = 0;
        tick();
        check("t5_gnt1_drop", 32'(bus.gnt1), 0);
        check("t5_idle", 32'(bus.busy), 0);
        bus.req0 = 1; bus.req1 = 1;
        tick(); tick();
        check("t5_tie2_gnt0", 32'(bus.gnt0), 1);
        check("t5_tie2_gnt1", 32'(bus.gnt1), 0);

        // T6: reset asserted in the cycle a write would be accepted
        do_reset();
        bus.req0 = 1;
        tick(); tick();
        bus.wr0 = 1; bus.addr0 = 12'h033; bus.data0 = 8'h77;
        reset = 1;
        tick();
        check("t6_we", 32'(bus.ram_write_enable), 0);
        check("t6_addr", 32'(bus.ram_address), 0);
        check("t6_gnt0", 32'(bus.gnt0), 0);
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_wait", 32'(bus.wait_count), 0);
        reset = 0;
        idle_inputs();

        // Saturation: req1 starves behind an idle req0 burst, so wait_count stops at 255
        do_reset();
        bus.req0 = 1; bus.req1 = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            check("sat_mutex", 32'(bus.gnt0 & bus.gnt1), 0);
        end
        check("sat_wait", 32'(bus.wait_count), 255);
        check("sat_gnt0", 32'(bus.gnt0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
